// File: rtl/mrf_tx_scheduler.sv
// MRF tx word builder: event slot (comma / round-robin events / null) in [15:8],
// data slot alternating distributed bus and a framed, checksummed buffer stream in [7:0].
module mrf_tx_scheduler #(
   parameter int unsigned EVT_REQ_N    = 4,
   parameter int unsigned COMMA_PERIOD = 8,
   parameter int unsigned BUF_LEN_W    = 8
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   ready,
   input  logic [EVT_REQ_N-1:0]   evt_valid,
   input  logic [8*EVT_REQ_N-1:0] evt_code,
   output logic [EVT_REQ_N-1:0]   evt_ready,
   input  logic [7:0]             dbus,
   input  logic                   buf_start,
   input  logic [BUF_LEN_W-1:0]   buf_len,
   input  logic [7:0]             buf_tdata,
   input  logic                   buf_tvalid,
   output logic                   buf_tready,
   output logic                   buf_busy,
   output logic                   buf_abort,
   output logic [15:0]            tx_data,
   output logic [1:0]             tx_is_k
);

   localparam int unsigned CNT_W = (COMMA_PERIOD > 2) ? $clog2(COMMA_PERIOD) : 1;
   localparam int unsigned PTR_W = (EVT_REQ_N > 1) ? $clog2(EVT_REQ_N) : 1;
   localparam int unsigned PAD_N = 2 ** PTR_W;
   localparam logic [7:0]  K28_5 = 8'hBC;
   localparam logic [7:0]  K28_0 = 8'h1C;
   localparam logic [7:0]  K28_1 = 8'h3C;

   typedef enum logic [2:0] {S_IDLE, S_SOF, S_DATA, S_CKH, S_CKL, S_EOF} buf_state_t;

   buf_state_t           state_q, state_d;
   logic [CNT_W-1:0]     comma_q, comma_d;
   logic                 parity_q, parity_d;
   logic [PTR_W-1:0]     rr_q, rr_d;
   logic [BUF_LEN_W-1:0] rem_q, rem_d;
   logic [15:0]          sum_q, sum_d;
   logic [15:0]          ck;
   logic [15:0]          tx_data_d;
   logic [1:0]           tx_is_k_d;
   logic                 busy_d, abort_d;
   logic [EVT_REQ_N-1:0] evt_ready_c;
   logic                 buf_tready_c;

   logic [PAD_N-1:0]     valid_pad;
   logic [7:0]           code_arr [PAD_N];
   logic                 gnt_found;
   logic [PTR_W-1:0]     gnt_idx;
   logic [PTR_W-1:0]     scan;

   // Pad requesters to a power of two so the pointer can index directly
   assign valid_pad = PAD_N'(evt_valid);
   for (genvar g = 0; g < PAD_N; g++) begin : g_code
      if (g < EVT_REQ_N) begin : g_used
         assign code_arr[g] = evt_code[8*g +: 8];
      end else begin : g_pad
         assign code_arr[g] = 8'h00;
      end
   end

   // First pending requester at or after the round-robin pointer
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan      = '0;
      for (int unsigned k = 0; k < EVT_REQ_N; k++) begin
         scan = PTR_W'((32'(rr_q) + k) % EVT_REQ_N);
         if (!gnt_found && valid_pad[scan]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan;
         end
      end
   end

   assign ck = 16'hFFFF - sum_q;

   // Next word, counters and buffer FSM
   always_comb begin
      state_d      = state_q;
      comma_d      = comma_q;
      parity_d     = parity_q;
      rr_d         = rr_q;
      rem_d        = rem_q;
      sum_d        = sum_q;
      tx_data_d    = '0;
      tx_is_k_d    = '0;
      busy_d       = 1'b0;
      abort_d      = 1'b0;
      evt_ready_c  = '0;
      buf_tready_c = 1'b0;

      if (!ready) begin
         comma_d  = '0;
         parity_d = 1'b0;
         rr_d     = '0;
         state_d  = S_IDLE;
         abort_d  = (state_q != S_IDLE);
      end else begin
         comma_d  = (comma_q == CNT_W'(COMMA_PERIOD - 1)) ? '0 : comma_q + CNT_W'(1);
         parity_d = ~parity_q;

         if (comma_q == '0) begin
            tx_data_d[15:8] = K28_5;
            tx_is_k_d[1]    = 1'b1;
         end else if (gnt_found) begin
            evt_ready_c     = EVT_REQ_N'(1) << gnt_idx;
            tx_data_d[15:8] = code_arr[gnt_idx];
            rr_d            = (gnt_idx == PTR_W'(EVT_REQ_N - 1)) ? '0 : gnt_idx + PTR_W'(1);
         end

         tx_data_d[7:0] = dbus;
         if (parity_q) begin
            case (state_q)
               S_SOF: begin
                  tx_data_d[7:0] = K28_0;
                  tx_is_k_d[0]   = 1'b1;
                  sum_d          = '0;
                  state_d        = S_DATA;
               end
               S_DATA: begin
                  if (buf_tvalid) begin
                     tx_data_d[7:0] = buf_tdata;
                     buf_tready_c   = 1'b1;
                     sum_d          = sum_q + 16'(buf_tdata);
                     rem_d          = rem_q - BUF_LEN_W'(1);
                     if (rem_q == BUF_LEN_W'(1)) state_d = S_CKH;
                  end else begin
                     tx_data_d[7:0] = 8'h00;
                  end
               end
               S_CKH: begin
                  tx_data_d[7:0] = ck[15:8];
                  state_d        = S_CKL;
               end
               S_CKL: begin
                  tx_data_d[7:0] = ck[7:0];
                  state_d        = S_EOF;
               end
               S_EOF: begin
                  tx_data_d[7:0] = K28_1;
                  tx_is_k_d[0]   = 1'b1;
                  state_d        = S_IDLE;
               end
               default: state_d = state_q;
            endcase
         end

         // Zero-length requests carry no frame at all
         if (state_q == S_IDLE && buf_start && buf_len != '0) begin
            state_d = S_SOF;
            rem_d   = buf_len;
         end
         busy_d = (state_d != S_IDLE);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= S_IDLE;
         comma_q   <= '0;
         parity_q  <= 1'b0;
         rr_q      <= '0;
         rem_q     <= '0;
         sum_q     <= '0;
         tx_data   <= '0;
         tx_is_k   <= '0;
         buf_busy  <= 1'b0;
         buf_abort <= 1'b0;
      end else begin
         state_q   <= state_d;
         comma_q   <= comma_d;
         parity_q  <= parity_d;
         rr_q      <= rr_d;
         rem_q     <= rem_d;
         sum_q     <= sum_d;
         tx_data   <= tx_data_d;
         tx_is_k   <= tx_is_k_d;
         buf_busy  <= busy_d;
         buf_abort <= abort_d;
      end
   end

   assign evt_ready  = evt_ready_c;
   assign buf_tready = buf_tready_c;

endmodule

// File: doc/mrf_tx_scheduler.md
Name: mrf_tx_scheduler

Overview:
- Builds the 16-bit MRF event-stream word sent to the GTP transmitter every tx word clock. It replaces the fixed-pattern frame generator in the MRF section.
- Upper byte is the event slot. It is shared by a periodic K28.5 comma, N round-robin event requesters and a null event.
- Lower byte is the data slot. It alternates between the distributed bus and a framed data-buffer stream.
- Sits between the event sources and the gtpwizard/gtp_model tx_data/txcharisk inputs.

Parameters:
- EVT_REQ_N, 4, number of event requesters (1..8).
- COMMA_PERIOD, 8, words between forced K28.5 in the event slot (2..256).
- BUF_LEN_W, 8, width of buf_len; maximum buffer length is 2**BUF_LEN_W-1 bytes.

Ports:
- aclk  in  1  GTP tx user clock (mrf_tx_clk).
- aresetn  in  1  asynchronous active-low reset.
- ready  in  1  tx_reset_done; low forces the idle output.
- evt_valid  in  EVT_REQ_N  per-requester event pending.
- evt_code  in  8*EVT_REQ_N  event codes; requester i uses bits [8i+7:8i].
- evt_ready  out  EVT_REQ_N  one-hot accept strobe.
- dbus  in  8  distributed bus value.
- buf_start  in  1  pulse: start a buffer transfer.
- buf_len  in  BUF_LEN_W  byte count, sampled on buf_start.
- buf_tdata  in  8  buffer byte.
- buf_tvalid  in  1  buffer byte valid.
- buf_tready  out  1  buffer byte consumed.
- buf_busy  out  1  transfer in progress.
- buf_abort  out  1  1-cycle pulse: transfer killed by ready drop.
- tx_data  out  16  [15:8] event slot, [7:0] data slot.
- tx_is_k  out  2  [1] event slot is K, [0] data slot is K.

Behaviour:
- Reset values: tx_data=0, tx_is_k=0, evt_ready=0, buf_tready=0, buf_busy=0, buf_abort=0. The round-robin pointer resets to 0, the comma counter and word parity to 0, and the buffer FSM to IDLE.
- ready low: same output values as reset; counters and pointer are held at reset values. If the buffer FSM is not IDLE when ready falls, it goes to IDLE and buf_abort pulses for one cycle.
- Outputs are registered. A word decided in cycle t appears on tx_data/tx_is_k at t+1.
- Word index: the word counter starts at 0 on the first ready-high cycle. Parity toggles every word: even words are 0, 2, ...
- Event slot priority, per word:
  - Comma counter == 0: 0xBC with is_k[1]=1. No grant is given that word.
  - Else any evt_valid set: grant the first set requester at or after the RR pointer, wrapping modulo EVT_REQ_N. evt_ready[g]=1 combinationally in that cycle. The code is sent with is_k[1]=0, and the pointer becomes g+1 mod N.
  - Else 0x00 with is_k[1]=0.
- Comma counter: counts 0..COMMA_PERIOD-1 and wraps to 0. The first word after ready rises is therefore a comma.
- Data slot, even words: dbus sampled in that cycle, is_k[0]=0.
- Data slot, odd words: driven by the buffer FSM:
  - IDLE: sends dbus. buf_start with buf_len!=0 goes to SOF; buf_len==0 is ignored.
  - SOF: sends 0x1C (K28.0) with is_k[0]=1, clears the 16-bit checksum, then goes to DATA.
  - DATA: if buf_tvalid, sends buf_tdata, asserts buf_tready that cycle, adds the byte to the checksum and decrements the remaining count. If not buf_tvalid, sends 0x00 with no count change (stall). After the last byte, goes to CKH.
  - CKH: sends the high byte of (0xFFFF - sum), then goes to CKL.
  - CKL: sends the low byte, then goes to EOF.
  - EOF: sends 0x3C (K28.1) with is_k[0]=1, then goes to IDLE.
- buf_busy is high from the cycle after buf_start until EOF has been sent.
- buf_tready is only ever asserted on odd words in DATA.
- buf_start while busy is ignored.
- Checksum is a mod-2^16 sum of the data bytes.
- evt_ready is never asserted while ready is low or on comma words. Requester valid/code must be held until accepted.

Test Plan:
- ready rises with no requests, dbus=0x5A, COMMA_PERIOD=8:
  - words 0 and 8 are 0xBC5A with is_k=10.
  - words 1..7 are 0x005A with is_k=00.
- All 4 evt_valid held, codes 0x11/0x22/0x33/0x44:
  - grants go 0, 1, 2, 3, 0, ... in round-robin order, skipping comma words.
  - each code appears at the cycle after its evt_ready.
- A requester is valid only on a comma word: no evt_ready that cycle; it is granted the next word.
- buf_start with buf_len=3, bytes 0x01 0x02 0x03, tvalid always high:
  - odd-word data slots carry 1C(K) 01 02 03 FF F9 3C(K).
  - even words carry dbus.
  - buf_busy falls after EOF.
- Same transfer with tvalid low for 2 odd words mid-stream: 0x00 is inserted and the checksum is unchanged.
- ready dropped during DATA: next cycle buf_abort=1 and tx_data=0. After ready returns, the first word is 0xBC with the data slot carrying dbus.
- aresetn asserted mid-grant: all outputs are 0 immediately (asynchronous); the RR pointer restarts at requester 0.
